pwm_multicanal: RTL and testbench

Parametrised multi-channel PWM generator; successor to the single-channel 8-bit `PWM` block.
- N channels share one timebase counter with a programmable clock prescaler.
- Each channel has a double-buffered duty register, so a new duty value takes effect only at a period boundary and never produces a glitch.
- Sits between the control logic that produces `Dato` words and the output pins or filters that consume `PWM_out`.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_canal.sv | 50 +++++
 rtl/pwm_multicanal.sv | 106 ++++++++++
 tb/tb_pwm_multicanal.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default parameters for the multi-channel PWM generator.
// Optional center-aligned mode is selected by defining PWM_CENTRO_ALINEADO_EN.
package pwm_pkg;

  localparam int unsigned DEF_N_CANALES = 4;
  localparam int unsigned DEF_ANCHO     = 8;
  localparam int unsigned DEF_PRESC_DIV = 1;

  // Duty word at the default width.
  typedef logic [DEF_ANCHO-1:0] duty_t;

  // Count direction; only used when center-aligned mode is built.
  typedef enum logic {
    DirSubir = 1'b0,
    DirBajar = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_canal.sv
// One PWM channel: shadow duty register, active duty register and registered
// compare output. The active duty only changes on the period boundary strobe.
module pwm_canal
  import pwm_pkg::*;
#(
  parameter int unsigned ANCHO = DEF_ANCHO
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             cargar,
  input  logic             frontera,
  input  logic [ANCHO-1:0] cnt,
  input  logic [ANCHO-1:0] dato,
  output logic             pwm_out
);

  logic [ANCHO-1:0] sombra_q, sombra_d;
  logic [ANCHO-1:0] activo_q, activo_d;
  logic             pwm_q, pwm_d;

  // Next state: activo takes the pre-edge shadow, so a coincident load waits a period.
  always_comb begin
    sombra_d = sombra_q;
    activo_d = activo_q;
    if (cargar) begin
      sombra_d = dato;
    end
    if (frontera) begin
      activo_d = sombra_q;
    end
    pwm_d = habilitar && (cnt < activo_q);
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sombra_q <= '0;
      activo_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      sombra_q <= sombra_d;
      activo_q <= activo_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multicanal.sv
// Multi-channel PWM top: prescaler, shared timebase counter and period-end pulse.
// Define PWM_CENTRO_ALINEADO_EN to build the up/down (center-aligned) timebase.
module pwm_multicanal
  import pwm_pkg::*;
#(
  parameter int unsigned N_CANALES = DEF_N_CANALES,
  parameter int unsigned ANCHO     = DEF_ANCHO,
  parameter int unsigned PRESC_DIV = DEF_PRESC_DIV
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       habilitar,
  input  logic [N_CANALES*ANCHO-1:0] Dato,
  input  logic [N_CANALES-1:0]       cargar,
  output logic [N_CANALES-1:0]       PWM_out,
  output logic                       fin_periodo
);

  // One-bit prescaler when PRESC_DIV is 1 avoids a zero-width vector.
  localparam int unsigned      PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_FIN = PW'(PRESC_DIV - 1);
  localparam logic [ANCHO-1:0] CNT_MAX   = '1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [ANCHO-1:0] cnt_q, cnt_d;
  logic             fin_q;
  logic             tick;
  logic             frontera;

`ifdef PWM_CENTRO_ALINEADO_EN
  dir_t dir_q, dir_d;

  // Direction flag register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      dir_q <= DirSubir;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  // Prescaler and timebase next-state; frontera marks the reload tick.
  always_comb begin
    tick     = habilitar && (presc_q == PRESC_FIN);
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    frontera = 1'b0;
    if (habilitar) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
`ifdef PWM_CENTRO_ALINEADO_EN
    dir_d = dir_q;
    if (tick) begin
      if (dir_q == DirSubir) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX - 1'b1) begin
          dir_d = DirBajar;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ANCHO'(1)) begin
          dir_d    = DirSubir;
          frontera = 1'b1;
        end
      end
    end
`else
    if (tick) begin
      cnt_d    = cnt_q + 1'b1;  // wraps MAX -> 0
      frontera = (cnt_q == CNT_MAX);
    end
`endif
  end

  // Prescaler, counter and period-end pulse registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      fin_q   <= frontera;
    end
  end

  assign fin_periodo = fin_q;

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    pwm_canal #(
      .ANCHO(ANCHO)
    ) u_canal (
      .clk_in   (clk_in),
      .reset    (reset),
      .habilitar(habilitar),
      .cargar   (cargar[i]),
      .frontera (frontera),
      .cnt      (cnt_q),
      .dato     (Dato[i*ANCHO +: ANCHO]),
      .pwm_out  (PWM_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal: a 4-channel W=8 instance, a 1-channel
// PRESC_DIV=3 instance and, with PWM_CENTRO_ALINEADO_EN, a W=4 instance.
module tb_pwm_multicanal;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: N=4, W=8, PRESC_DIV=1.
  logic        rst0 = 1'b1, en0 = 1'b1, fin0;
  logic [31:0] dato0 = '1;
  logic [3:0]  carg0 = 4'hF, pwm0;

  pwm_multicanal #(.N_CANALES(4), .ANCHO(8), .PRESC_DIV(1)) dut0 (
    .clk_in(clk), .reset(rst0), .habilitar(en0), .Dato(dato0),
    .cargar(carg0), .PWM_out(pwm0), .fin_periodo(fin0)
  );

  // Instance 1: N=1, W=8, PRESC_DIV=3.
  logic       rst1 = 1'b1, en1 = 1'b1, fin1;
  logic [7:0] dato1 = '0;
  logic [0:0] carg1 = 1'b0, pwm1;

  pwm_multicanal #(.N_CANALES(1), .ANCHO(8), .PRESC_DIV(3)) dut1 (
    .clk_in(clk), .reset(rst1), .habilitar(en1), .Dato(dato1),
    .cargar(carg1), .PWM_out(pwm1), .fin_periodo(fin1)
  );

`ifdef PWM_CENTRO_ALINEADO_EN
  logic       rst2 = 1'b1, en2 = 1'b1, fin2;
  logic [3:0] dato2 = '0;
  logic [0:0] carg2 = 1'b0, pwm2;

  pwm_multicanal #(.N_CANALES(1), .ANCHO(4), .PRESC_DIV(1)) dut2 (
    .clk_in(clk), .reset(rst2), .habilitar(en2), .Dato(dato2),
    .cargar(carg2), .PWM_out(pwm2), .fin_periodo(fin2)
  );
`endif

  int hi0 [4];
  int len0;
  int hi1, hi_dis1, len1;

  // Runs instance 0 until the next fin_periodo, loading mask/data at edge index ld_at.
  task automatic run_period0(input int ld_at, input logic [3:0] mask, input logic [31:0] data);
    len0 = 0;
    for (int c = 0; c < 4; c++) hi0[c] = 0;
    dato0 = data;
    while (len0 < 2000) begin
      carg0 = (len0 == ld_at) ? mask : 4'b0;
      @(posedge clk); #1;
      len0++;
      for (int c = 0; c < 4; c++) if (pwm0[c]) hi0[c]++;
      if (fin0) break;
    end
    carg0 = 4'b0;
    if (fin0 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL period0_timeout: fin_periodo=%b after %0d cycles, want 1", fin0, len0);
    end
  endtask

  // Runs instance 1 until the next fin_periodo, optionally loading and disabling.
  task automatic run_period1(input int ld_at, input logic [7:0] data,
                             input int dis_at, input int dis_len);
    len1 = 0; hi1 = 0; hi_dis1 = 0;
    dato1 = data;
    while (len1 < 4000) begin
      carg1 = (len1 == ld_at) ? 1'b1 : 1'b0;
      en1   = !(len1 >= dis_at && len1 < dis_at + dis_len);
      @(posedge clk); #1;
      len1++;
      if (pwm1[0]) begin
        hi1++;
        if (!en1) hi_dis1++;
      end
      if (fin1) break;
    end
    carg1 = 1'b0;
    en1   = 1'b1;
    if (fin1 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL period1_timeout: fin_periodo=%b after %0d cycles, want 1", fin1, len1);
    end
  endtask

  task automatic test_reset();
    // Reset is held with cargar and habilitar high; reset must win.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (pwm0 !== 4'b0) begin
        errors++; $display("FAIL reset_pwm cycle %0d: got %b want 0000", k, pwm0);
      end
      checks++;
      if (fin0 !== 1'b0) begin
        errors++; $display("FAIL reset_fin cycle %0d: got %b want 0", k, fin0);
      end
    end
    rst0  = 1'b0;
    run_period0(-1, 4'b0, '0);
    checks++;
    if (len0 !== 256) begin
      errors++; $display("FAIL reset_first_fin: got %0d cycles want 256", len0);
    end
    // Shadows were cleared despite cargar during reset: next period stays low.
    run_period0(-1, 4'b0, '0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi0[c] !== 0) begin
        errors++; $display("FAIL reset_shadow ch%0d: got high %0d want 0", c, hi0[c]);
      end
    end
  endtask

  task automatic test_duty_sweep();
    int vals [5];
    int prev;
    vals = '{0, 1, 64, 128, 255};
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      run_period0(0, 4'b0001, {24'b0, 8'(vals[k])});
      checks++;
      if (hi0[0] !== prev || len0 !== 256) begin
        errors++;
        $display("FAIL sweep step %0d: got high %0d len %0d want high %0d len 256",
                 k, hi0[0], len0, prev);
      end
      prev = vals[k];
    end
    run_period0(-1, 4'b0, '0);
    checks++;
    if (hi0[0] !== 255 || len0 !== 256) begin
      errors++; $display("FAIL sweep_last: got high %0d len %0d want 255/256", hi0[0], len0);
    end
  endtask

  task automatic test_update_at_boundary();
    run_period0(0, 4'b0001, 32'd40);      // active 255, shadow -> 40
    checks++;
    if (hi0[0] !== 255) begin
      errors++; $display("FAIL boundary_a: got high %0d want 255", hi0[0]);
    end
    run_period0(255, 4'b0001, 32'd20);    // load coincides with the wrap edge
    checks++;
    if (hi0[0] !== 40) begin
      errors++; $display("FAIL boundary_b: got high %0d want 40", hi0[0]);
    end
    run_period0(-1, 4'b0, '0);            // old shadow (40) was reloaded
    checks++;
    if (hi0[0] !== 40) begin
      errors++; $display("FAIL boundary_old: got high %0d want 40", hi0[0]);
    end
    run_period0(-1, 4'b0, '0);
    checks++;
    if (hi0[0] !== 20) begin
      errors++; $display("FAIL boundary_new: got high %0d want 20", hi0[0]);
    end
  endtask

  task automatic test_channel_independence();
    int exp_hi [4];
    exp_hi = '{0, 85, 170, 255};
    run_period0(0, 4'hF, {8'd255, 8'd170, 8'd85, 8'd0});
    run_period0(-1, 4'b0, '0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi0[c] !== exp_hi[c]) begin
        errors++; $display("FAIL indep ch%0d: got high %0d want %0d", c, hi0[c], exp_hi[c]);
      end
    end
  endtask

  task automatic test_prescaler();
    rst1 = 1'b0;
    run_period1(0, 8'd10, 0, 0);
    checks++;
    if (len1 !== 768 || hi1 !== 0) begin
      errors++; $display("FAIL presc_first: got len %0d high %0d want 768/0", len1, hi1);
    end
    run_period1(-1, 8'd0, 0, 0);
    checks++;
    if (len1 !== 768 || hi1 !== 30) begin
      errors++; $display("FAIL presc_period: got len %0d high %0d want 768/30", len1, hi1);
    end
    // Disable for 50 cycles inside the high phase.
    run_period1(-1, 8'd0, 15, 50);
    checks++;
    if (len1 !== 818 || hi1 !== 30) begin
      errors++; $display("FAIL presc_disable: got len %0d high %0d want 818/30", len1, hi1);
    end
    checks++;
    if (hi_dis1 !== 0) begin
      errors++; $display("FAIL presc_disable_low: got %0d high while off want 0", hi_dis1);
    end
  endtask

  task automatic test_mid_reset();
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (pwm1 !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got %b want 1", pwm1);
    end
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    checks++;
    if (pwm1 !== 1'b0 || fin1 !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: got pwm %b fin %b want 0/0", pwm1, fin1);
    end
    run_period1(-1, 8'd0, 0, 0);
    checks++;
    if (len1 !== 768 || hi1 !== 0) begin
      errors++; $display("FAIL midreset_restart: got len %0d high %0d want 768/0", len1, hi1);
    end
  endtask

`ifdef PWM_CENTRO_ALINEADO_EN
  task automatic test_center_aligned();
    int n, h;
    for (int p = 0; p < 2; p++) begin
      n = 0; h = 0;
      dato2 = 4'd5;
      rst2  = 1'b0;
      while (n < 200) begin
        carg2 = (p == 0 && n == 0) ? 1'b1 : 1'b0;
        @(posedge clk); #1;
        n++;
        if (pwm2[0]) h++;
        if (fin2) break;
      end
      carg2 = 1'b0;
      // Second period: cnt<5 holds for 0..4 rising and 4..1 falling.
      checks++;
      if (n !== 30 || h !== ((p == 0) ? 0 : 9)) begin
        errors++; $display("FAIL center p%0d: got len %0d high %0d", p, n, h);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_duty_sweep();
    test_update_at_boundary();
    test_channel_independence();
    test_prescaler();
    test_mid_reset();
`ifdef PWM_CENTRO_ALINEADO_EN
    test_center_aligned();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
